// File: rtl/multdiv_pkg.sv
// Shared definitions for the multdiv issuer: operation codes, FSM state
// encoding and the default watchdog limit.
package multdiv_pkg;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int TIMEOUT_CYCLES_DEF = 40;

endpackage

// File: rtl/multdiv_watchdog.sv
// Watchdog counter for the WAIT state. Counts enabled cycles since the last
// clear; expired is high on the LIMIT-th enabled cycle, so the issuer can
// leave WAIT on the same edge that completes the allowance.
module multdiv_watchdog #(
    parameter int LIMIT = multdiv_pkg::TIMEOUT_CYCLES_DEF
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign expired = enable && (cnt_q == 8'(LIMIT - 1));

    // Next count: clear has priority; hold once expired so the counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multdiv_issuer.sv
// Requester-side controller for the multdiv unit. Takes one request, holds
// the unit's level-sensitive controls and operands until result-ready (or a
// watchdog timeout), then emits a single-cycle writeback beat. Divide-by-zero
// is answered locally without touching the unit.
module multdiv_issuer #(
    parameter int TIMEOUT_CYCLES = multdiv_pkg::TIMEOUT_CYCLES_DEF,
    parameter int RD_W           = 5
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   req_valid,
    input  logic                   req_op,
    input  logic signed [31:0]     req_a,
    input  logic signed [15:0]     req_b,
    input  logic [RD_W-1:0]        req_rd,
    output logic                   req_ready,
    output logic                   md_ctrl_mult,
    output logic                   md_ctrl_div,
    output logic signed [31:0]     md_operand_a,
    output logic signed [15:0]     md_operand_b,
    input  logic signed [31:0]     md_result,
    input  logic signed [31:0]     md_remainder,
    input  logic                   md_exception,
    input  logic                   md_result_rdy,
    output logic                   wb_valid,
    output logic [RD_W-1:0]        wb_rd,
    output logic signed [31:0]     wb_result,
    output logic signed [31:0]     wb_remainder,
    output logic                   wb_exception,
    output logic                   stall,
    input  logic                   fault_clear,
    output logic                   fault_timeout
);

    import multdiv_pkg::*;

    state_t                state_q, state_d;
    logic                  op_q, op_d;
    logic [RD_W-1:0]       rd_q, rd_d;
    logic signed [31:0]    a_q, a_d;
    logic signed [15:0]    b_q, b_d;
    logic [RD_W-1:0]       wb_rd_q, wb_rd_d;
    logic signed [31:0]    wb_result_q, wb_result_d;
    logic signed [31:0]    wb_remainder_q, wb_remainder_d;
    logic                  wb_exception_q, wb_exception_d;
    logic                  fault_q, fault_d;
    logic                  wd_clear, wd_en, wd_expired;
    logic                  busy;

    multdiv_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .resetn  (resetn),
        .clear   (wd_clear),
        .enable  (wd_en),
        .expired (wd_expired)
    );

    // Controls are decoded straight from state so an async reset drops them at once.
    assign busy          = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    assign md_ctrl_mult  = busy && (op_q == OP_MULT);
    assign md_ctrl_div   = busy && (op_q == OP_DIV);
    assign md_operand_a  = a_q;
    assign md_operand_b  = b_q;
    assign req_ready     = (state_q == ST_IDLE);
    assign stall         = (state_q != ST_IDLE);
    assign wb_valid      = (state_q == ST_DONE);
    assign wb_rd         = wb_rd_q;
    assign wb_result     = wb_result_q;
    assign wb_remainder  = wb_remainder_q;
    assign wb_exception  = wb_exception_q;
    assign fault_timeout = fault_q;

    // Next-state, request latching, writeback payload and sticky fault.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        rd_d           = rd_q;
        a_d            = a_q;
        b_d            = b_q;
        wb_rd_d        = wb_rd_q;
        wb_result_d    = wb_result_q;
        wb_remainder_d = wb_remainder_q;
        wb_exception_d = wb_exception_q;
        // Clear first so a timeout set in the same cycle overrides it.
        fault_d        = fault_q && !fault_clear;
        wd_clear       = 1'b0;
        wd_en          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    rd_d = req_rd;
                    a_d  = req_a;
                    b_d  = req_b;
                    if ((req_op == OP_DIV) && (req_b == '0)) begin
                        wb_rd_d        = req_rd;
                        wb_result_d    = '0;
                        wb_remainder_d = '0;
                        wb_exception_d = 1'b1;
                        state_d        = ST_DONE;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                wd_clear = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_en = 1'b1;
                // A result arriving on the expiry cycle still wins.
                if (md_result_rdy) begin
                    wb_rd_d        = rd_q;
                    wb_result_d    = md_result;
                    wb_remainder_d = (op_q == OP_MULT) ? 32'sd0 : md_remainder;
                    wb_exception_d = md_exception;
                    state_d        = ST_DONE;
                end else if (wd_expired) begin
                    wb_rd_d        = rd_q;
                    wb_result_d    = '0;
                    wb_remainder_d = '0;
                    wb_exception_d = 1'b1;
                    fault_d        = 1'b1;
                    state_d        = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and writeback payload registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_MULT;
            rd_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            wb_rd_q        <= '0;
            wb_result_q    <= '0;
            wb_remainder_q <= '0;
            wb_exception_q <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            rd_q           <= rd_d;
            a_q            <= a_d;
            b_q            <= b_d;
            wb_rd_q        <= wb_rd_d;
            wb_result_q    <= wb_result_d;
            wb_remainder_q <= wb_remainder_d;
            wb_exception_q <= wb_exception_d;
            fault_q        <= fault_d;
        end
    end

endmodule

// File: tb/tb_multdiv_issuer.sv
// Directed bench for multdiv_issuer. Two instances share request payload and
// unit-result inputs: u_long uses the default 40-cycle watchdog, u_short an
// 8-cycle one; each has its own req_valid and result-ready.
module tb_multdiv_issuer;

    logic        clock;
    logic        resetn;
    logic        req_op;
    logic [31:0] req_a;
    logic [15:0] req_b;
    logic [4:0]  req_rd;
    logic [31:0] md_result;
    logic [31:0] md_remainder;
    logic        md_exception;
    logic        fault_clear;

    logic        l_valid, l_rdy;
    logic        l_ready, l_mult, l_div, l_wb_valid, l_wb_exc, l_stall, l_fault;
    logic [31:0] l_op_a, l_wb_result, l_wb_rem;
    logic [15:0] l_op_b;
    logic [4:0]  l_wb_rd;

    logic        s_valid, s_rdy;
    logic        s_ready, s_mult, s_div, s_wb_valid, s_wb_exc, s_stall, s_fault;
    logic [31:0] s_op_a, s_wb_result, s_wb_rem;
    logic [15:0] s_op_b;
    logic [4:0]  s_wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    multdiv_issuer #(.TIMEOUT_CYCLES(40), .RD_W(5)) u_long (
        .clock(clock), .resetn(resetn),
        .req_valid(l_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .req_ready(l_ready), .md_ctrl_mult(l_mult), .md_ctrl_div(l_div),
        .md_operand_a(l_op_a), .md_operand_b(l_op_b),
        .md_result(md_result), .md_remainder(md_remainder), .md_exception(md_exception),
        .md_result_rdy(l_rdy),
        .wb_valid(l_wb_valid), .wb_rd(l_wb_rd), .wb_result(l_wb_result),
        .wb_remainder(l_wb_rem), .wb_exception(l_wb_exc), .stall(l_stall),
        .fault_clear(fault_clear), .fault_timeout(l_fault)
    );

    multdiv_issuer #(.TIMEOUT_CYCLES(8), .RD_W(5)) u_short (
        .clock(clock), .resetn(resetn),
        .req_valid(s_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .req_ready(s_ready), .md_ctrl_mult(s_mult), .md_ctrl_div(s_div),
        .md_operand_a(s_op_a), .md_operand_b(s_op_b),
        .md_result(md_result), .md_remainder(md_remainder), .md_exception(md_exception),
        .md_result_rdy(s_rdy),
        .wb_valid(s_wb_valid), .wb_rd(s_wb_rd), .wb_result(s_wb_result),
        .wb_remainder(s_wb_rem), .wb_exception(s_wb_exc), .stall(s_stall),
        .fault_clear(fault_clear), .fault_timeout(s_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0; req_rd = '0;
        md_result = '0; md_remainder = '0; md_exception = 1'b0; fault_clear = 1'b0;
        l_valid = 1'b0; l_rdy = 1'b0; s_valid = 1'b0; s_rdy = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_ready_stall", {l_ready, l_stall}, 2'b10);
        check("rst_ctrl", {l_mult, l_div, l_wb_valid, l_wb_exc, l_fault, s_fault}, 6'b0);
        check("rst_operands", {l_op_a, l_op_b}, 48'h0);
        check("rst_payload", {l_wb_result, l_wb_rem}, 64'h0);
        check("rst_wb_rd", l_wb_rd, 5'd0);
        resetn = 1'b1;
        tick();

        // Multiply 7 * -3, result-ready on the 5th WAIT cycle
        l_valid = 1'b1; req_op = 1'b0; req_a = 32'd7; req_b = 16'hFFFD; req_rd = 5'd5;
        check("mul_accept_ready", {l_ready, l_stall}, 2'b10);
        tick();
        l_valid = 1'b0;
        check("mul_launch_ctrl", {l_mult, l_div, l_stall, l_wb_valid}, 4'b1010);
        check("mul_launch_ops", {l_op_a, l_op_b}, {32'd7, 16'hFFFD});
        tick();
        for (int i = 1; i <= 4; i++) begin
            check("mul_wait_hold", {l_mult, l_div, l_stall, l_wb_valid, l_ready}, 5'b10100);
            tick();
        end
        l_rdy = 1'b1; md_result = 32'hFFFF_FFEB; md_remainder = 32'h0000_1234; md_exception = 1'b0;
        tick();
        l_rdy = 1'b0;
        check("mul_done_ctrl", {l_wb_valid, l_stall, l_mult, l_ready}, 4'b1100);
        check("mul_result", l_wb_result, 32'hFFFF_FFEB);
        check("mul_rem_forced0", l_wb_rem, 32'h0);
        check("mul_exc_rd", {l_wb_exc, l_wb_rd}, {1'b0, 5'd5});
        tick();
        check("mul_after", {l_wb_valid, l_stall, l_ready}, 3'b001);
        check("mul_payload_hold", l_wb_result, 32'hFFFF_FFEB);

        // Divide 100 / 7, ready pulse in LAUNCH ignored, real ready on 33rd WAIT cycle
        l_valid = 1'b1; req_op = 1'b1; req_a = 32'd100; req_b = 16'd7; req_rd = 5'd9;
        tick();
        l_valid = 1'b0;
        l_rdy = 1'b1; md_result = 32'hDEAD_BEEF; md_remainder = 32'h1; md_exception = 1'b1;
        check("div_launch_ctrl", {l_div, l_mult, l_wb_valid}, 3'b100);
        tick();
        l_rdy = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            check("div_wait_hold", {l_div, l_mult, l_wb_valid}, 3'b100);
            tick();
        end
        l_rdy = 1'b1; md_result = 32'd14; md_remainder = 32'd2; md_exception = 1'b0;
        tick();
        l_rdy = 1'b0;
        check("div_done", {l_wb_valid, l_div, l_mult}, 3'b100);
        check("div_q_r", {l_wb_result, l_wb_rem}, {32'd14, 32'd2});
        check("div_exc_rd", {l_wb_exc, l_wb_rd}, {1'b0, 5'd9});
        tick();

        // Divide by zero: answered locally at T+1
        l_valid = 1'b1; req_op = 1'b1; req_a = 32'd55; req_b = 16'd0; req_rd = 5'd3;
        tick();
        l_valid = 1'b0;
        check("dz_done", {l_wb_valid, l_wb_exc, l_div, l_mult, l_stall}, 5'b11001);
        check("dz_payload", {l_wb_result, l_wb_rem}, 64'h0);
        check("dz_rd", l_wb_rd, 5'd3);
        tick();
        check("dz_after", {l_wb_valid, l_ready, l_div}, 3'b010);

        // Timeout on the 8-cycle instance: wb_valid at T+10
        s_valid = 1'b1; req_op = 1'b0; req_a = 32'd3; req_b = 16'd4; req_rd = 5'd7;
        md_result = 32'h5555_5555; md_remainder = 32'h6666_6666; md_exception = 1'b0;
        tick();
        s_valid = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            check("to_no_early_wb", {s_wb_valid, s_fault}, 2'b00);
            tick();
        end
        check("to_done", {s_wb_valid, s_wb_exc, s_fault}, 3'b111);
        check("to_payload", {s_wb_result, s_wb_rem}, 64'h0);
        check("to_rd", s_wb_rd, 5'd7);
        tick();
        check("to_sticky_idle", {s_fault, s_ready}, 2'b11);

        // Good op afterwards: fault stays set
        s_valid = 1'b1; req_op = 1'b0; req_a = 32'd2; req_b = 16'd3; req_rd = 5'd4;
        tick();
        s_valid = 1'b0;
        tick();
        s_rdy = 1'b1; md_result = 32'd6; md_remainder = 32'd0; md_exception = 1'b0;
        tick();
        s_rdy = 1'b0;
        check("good_after_to", {s_wb_valid, s_wb_exc, s_wb_result}, {1'b1, 1'b0, 32'd6});
        check("fault_sticky", s_fault, 1'b1);
        tick();
        fault_clear = 1'b1;
        check("fault_before_clear", s_fault, 1'b1);
        tick();
        fault_clear = 1'b0;
        check("fault_cleared", s_fault, 1'b0);

        // Timeout while fault_clear held: set wins
        s_valid = 1'b1; fault_clear = 1'b1; req_rd = 5'd2;
        tick();
        s_valid = 1'b0;
        for (int i = 1; i <= 9; i++) tick();
        check("set_wins_clear", {s_wb_valid, s_fault}, 2'b11);
        tick();
        check("clear_after_set", s_fault, 1'b0);
        fault_clear = 1'b0;
        tick();

        // Ready exactly on the expiry cycle: result wins
        s_valid = 1'b1; req_op = 1'b0; req_a = 32'hFFFF_FFFB; req_b = 16'd6; req_rd = 5'd1;
        tick();
        s_valid = 1'b0;
        for (int i = 1; i <= 8; i++) tick();
        s_rdy = 1'b1; md_result = 32'hFFFF_FFE2; md_remainder = 32'h7; md_exception = 1'b0;
        tick();
        s_rdy = 1'b0;
        check("edge_done", {s_wb_valid, s_wb_exc, s_fault}, 3'b100);
        check("edge_result", {s_wb_result, s_wb_rem}, {32'hFFFF_FFE2, 32'h0});
        tick();

        // Reset mid-WAIT on the long instance
        l_valid = 1'b1; req_op = 1'b0; req_a = 32'hFFFF_FFFC; req_b = 16'hFFFB; req_rd = 5'd6;
        tick();
        l_valid = 1'b0;
        tick(); tick();
        check("pre_reset_busy", {l_mult, l_stall}, 2'b11);
        resetn = 1'b0;
        #1;
        check("async_reset_ctrl", {l_mult, l_div, l_stall, l_wb_valid, l_ready}, 5'b00001);
        check("async_reset_payload", {l_op_a, l_wb_result}, 64'h0);
        tick();
        resetn = 1'b1;
        check("post_reset_ready", {l_ready, l_wb_valid}, 2'b10);
        tick();
        check("no_wb_after_reset", {l_wb_valid, l_stall}, 2'b00);

        // New multiply after reset: -4 * -5 = 20
        l_valid = 1'b1;
        tick();
        l_valid = 1'b0;
        check("rmul_launch", {l_mult, l_op_a, l_op_b}, {1'b1, 32'hFFFF_FFFC, 16'hFFFB});
        tick();
        l_rdy = 1'b1; md_result = 32'd20; md_remainder = 32'h9; md_exception = 1'b0;
        tick();
        l_rdy = 1'b0;
        check("rmul_done", {l_wb_valid, l_wb_exc, l_wb_rd}, {1'b1, 1'b0, 5'd6});
        check("rmul_result", {l_wb_result, l_wb_rem}, {32'd20, 32'd0});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
